// File: rtl/bus_split_router_if.sv
// Producer/consumer bus bundle for bus_split_router.
// master = producer plus both sinks (drives data and readys), slave = router.
interface bus_split_router_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             map_wr_en;
    logic [WIDTH-1:0] map_wr_data;
    logic [WIDTH-1:0] map_q;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [15:0]      word_cnt;

    modport master (
        output in_valid, in_data, map_wr_en, map_wr_data, a_ready, b_ready,
        input  in_ready, map_q, a_valid, a_data, b_valid, b_data, word_cnt
    );

    modport slave (
        input  in_valid, in_data, map_wr_en, map_wr_data, a_ready, b_ready,
        output in_ready, map_q, a_valid, a_data, b_valid, b_data, word_cnt
    );
endinterface

// File: rtl/bus_split_router.sv
// Splits each accepted input word bit-wise onto bus A (map bit 0) or bus B
// (map bit 1). Each output owns a 2-entry FIFO so the sinks drain independently.
module bus_split_router #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] MAP_RESET = '0
) (
    input logic               clk,
    input logic               rst,
    bus_split_router_if.slave bus
);
    logic [WIDTH-1:0] map_r;
    logic [15:0]      cnt_r;
    // Per channel (0 = A, 1 = B) shift-style FIFO; slot 0 is always the head.
    logic [WIDTH-1:0] fifo_mem [2][2];
    logic [1:0]       fifo_cnt [2];
    logic [WIDTH-1:0] push_data [2];
    logic             pop [2];
    logic             accept;

    // Input is gated only by FIFO occupancy, never by sink readiness.
    assign bus.in_ready = (fifo_cnt[0] != 2'd2) && (fifo_cnt[1] != 2'd2);
    assign bus.map_q    = map_r;
    assign bus.word_cnt = cnt_r;
    assign bus.a_valid  = (fifo_cnt[0] != 2'd0);
    assign bus.b_valid  = (fifo_cnt[1] != 2'd0);
    assign bus.a_data   = (fifo_cnt[0] != 2'd0) ? fifo_mem[0][0] : '0;
    assign bus.b_data   = (fifo_cnt[1] != 2'd0) ? fifo_mem[1][0] : '0;

    // Handshake decode and split of the incoming word with the current (old) map.
    always_comb begin
        accept       = bus.in_valid && bus.in_ready;
        push_data[0] = bus.in_data & ~map_r;
        push_data[1] = bus.in_data &  map_r;
        pop[0]       = bus.a_ready && (fifo_cnt[0] != 2'd0);
        pop[1]       = bus.b_ready && (fifo_cnt[1] != 2'd0);
    end

    // Route map register and accepted-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_r <= MAP_RESET;
            cnt_r <= '0;
        end else begin
            if (bus.map_wr_en) map_r <= bus.map_wr_data;
            if (accept)        cnt_r <= cnt_r + 16'd1;
        end
    end

    // Both FIFOs: push on accept, pop on sink handshake; push+pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                fifo_cnt[ch]    <= '0;
                fifo_mem[ch][0] <= '0;
                fifo_mem[ch][1] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                case ({accept, pop[ch]})
                    2'b10: begin
                        if (fifo_cnt[ch] == 2'd0) fifo_mem[ch][0] <= push_data[ch];
                        else                      fifo_mem[ch][1] <= push_data[ch];
                        fifo_cnt[ch] <= fifo_cnt[ch] + 2'd1;
                    end
                    2'b01: begin
                        fifo_mem[ch][0] <= fifo_mem[ch][1];
                        fifo_mem[ch][1] <= '0;
                        fifo_cnt[ch]    <= fifo_cnt[ch] - 2'd1;
                    end
                    2'b11: begin
                        // Head leaves while the new word lands behind whatever remains.
                        if (fifo_cnt[ch] == 2'd1) begin
                            fifo_mem[ch][0] <= push_data[ch];
                        end else begin
                            fifo_mem[ch][0] <= fifo_mem[ch][1];
                            fifo_mem[ch][1] <= push_data[ch];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
